// File: rtl/seq_div_24.sv
// rtl/seq_div_24.sv - sequential restoring divider, 2W/W -> W quotient and W remainder
module seq_div_24 #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [W-1:0]  r;
  logic [W-1:0]  q;
  logic [W-1:0]  divisor_r;
  logic [CW-1:0] cnt;

  logic [W:0]    t;
  logic          ge;
  logic [W-1:0]  r_n;
  logic [W-1:0]  q_n;
  logic          accept_ovf;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    t   = {r, q[W-1]};
    ge  = (t >= {1'b0, divisor_r});
    r_n = ge ? W'(t - {1'b0, divisor_r}) : t[W-1:0];
    q_n = {q[W-2:0], ge};
  end

  // A high half at or above the divisor cannot fit in a W-bit quotient; covers divisor==0.
  assign accept_ovf = (dividend[2*W-1:W] >= divisor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      r         <= '0;
      q         <= '0;
      divisor_r <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
          if (start) begin
            divisor_r <= divisor;
            if (accept_ovf) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= {W{1'b1}};
              remainder <= '0;
              ovf       <= 1'b1;
              div_zero  <= (divisor == '0);
            end else begin
              state    <= CALC;
              busy     <= 1'b1;
              r        <= dividend[2*W-1:W];
              q        <= dividend[W-1:0];
              cnt      <= '0;
              ovf      <= 1'b0;
              div_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          r   <= r_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_n;
            remainder <= r_n;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
